// File: rtl/apb_master_ctrl.sv
// APB3/APB4 requester: one valid/ready command becomes one APB transfer on a two-slave bus,
// and the outcome (read data, slave error or timeout) comes back on a valid/ready response port.
module apb_master_ctrl #(
  parameter int unsigned SEL_BIT     = 19,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  // command port
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [19:0] cmd_addr,
  input  logic [15:0] cmd_wdata,
  input  logic [1:0]  cmd_strb,
  // APB bus
  output logic [1:0]  psel,
  output logic        penable,
  output logic [19:0] paddr,
  output logic        pwrite,
  output logic [15:0] pwdata,
  output logic [1:0]  pstrb,
  input  logic [15:0] prdata,
  input  logic        pready,
  input  logic        pslverr,
  // response port
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYC - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] wait_cnt;
  logic       accept;
  logic       xfer_done;
  logic       xfer_abort;
  logic       rsp_taken;

  assign accept     = (state == IDLE) && cmd_ready && cmd_valid;
  assign xfer_done  = (state == ACCESS) && pready;
  // The terminal ACCESS cycle only aborts if the slave is still not ready on it.
  assign xfer_abort = (state == ACCESS) && !pready && (wait_cnt == WAIT_LAST);
  assign rsp_taken  = (state == RESP) && rsp_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // NOTE: next state is given a default before the case so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept)                   state_nxt = SETUP;
      SETUP:                                 state_nxt = ACCESS;
      ACCESS:  if (xfer_done || xfer_abort)  state_nxt = RESP;
      RESP:    if (rsp_taken)                state_nxt = IDLE;
      default:                               state_nxt = IDLE;
    endcase
  end

  // Bus strobes decode straight from the state register, so reset drops them asynchronously.
  always_comb begin
    psel = 2'b00;
    if ((state == SETUP) || (state == ACCESS)) psel[paddr[SEL_BIT]] = 1'b1;
  end

  assign penable   = (state == ACCESS);
  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_ready   <= 1'b0;
      paddr       <= '0;
      pwrite      <= 1'b0;
      pwdata      <= '0;
      pstrb       <= '0;
      wait_cnt    <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      cmd_ready <= (state_nxt == IDLE);

      if (accept) begin
        paddr  <= cmd_addr;
        pwrite <= cmd_write;
        pwdata <= cmd_wdata;
        pstrb  <= cmd_write ? cmd_strb : 2'b00;
      end

      if (state == SETUP)                 wait_cnt <= '0;
      else if (state == ACCESS && !pready) wait_cnt <= wait_cnt + 8'd1;

      if (xfer_done) begin
        rsp_rdata   <= pwrite ? 16'h0000 : prdata;
        rsp_err     <= pslverr;
        rsp_timeout <= 1'b0;
      end else if (xfer_abort) begin
        rsp_rdata   <= 16'h0000;
        rsp_err     <= 1'b1;
        rsp_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Self-checking bench for apb_master_ctrl: directed scenarios plus randomized transfers,
// each predicted from the transfer rules (wait states, timeout budget, error/read-data policy).
module tb_apb_master_ctrl;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [19:0] cmd_addr = '0;
  logic [15:0] cmd_wdata = '0;
  logic [1:0]  cmd_strb = '0;
  logic [1:0]  psel;
  logic        penable;
  logic [19:0] paddr;
  logic        pwrite;
  logic [15:0] pwdata;
  logic [1:0]  pstrb;
  logic [15:0] prdata = '0;
  logic        pready = 1'b0;
  logic        pslverr = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;

  int checks = 0;
  int failures = 0;

  apb_master_ctrl #(.SEL_BIT(19), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One complete transfer. waits = ACCESS cycles with pready=0 before pready=1 (>= TO never completes).
  task automatic xfer(input bit wr, input logic [19:0] addr, input logic [15:0] wd,
                      input logic [1:0] st, input int waits, input logic [15:0] rd,
                      input bit err, input int rdly, input bit hold_cmd);
    logic [1:0]  e_psel;
    bit          e_to;
    int          e_acc;
    logic [15:0] e_rd;
    bit          e_err;
    int          n;
    bit          last;
    e_psel = addr[19] ? 2'b10 : 2'b01;
    e_to   = (waits >= TO);
    e_acc  = e_to ? TO : waits + 1;
    e_rd   = (e_to || wr) ? 16'h0000 : rd;
    e_err  = e_to ? 1'b1 : err;

    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    if (!cmd_ready) return;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wd;
    cmd_strb  = st;

    @(negedge clk);
    if (!hold_cmd) cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_addr  = 20'($urandom);
    cmd_wdata = 16'($urandom);
    cmd_strb  = 2'($urandom);
    check("setup_psel", 32'(psel), 32'(e_psel));
    check("setup_penable", 32'(penable), 32'd0);
    check("setup_cmd_ready", 32'(cmd_ready), 32'd0);
    check("setup_paddr", 32'(paddr), 32'(addr));
    check("setup_pwrite", 32'(pwrite), 32'(wr));
    check("setup_pwdata", 32'(pwdata), 32'(wd));
    check("setup_pstrb", 32'(pstrb), 32'(wr ? st : 2'b00));

    for (int i = 0; i < e_acc; i++) begin
      @(negedge clk);
      check("access_psel", 32'(psel), 32'(e_psel));
      check("access_penable", 32'(penable), 32'd1);
      check("access_paddr", 32'(paddr), 32'(addr));
      check("access_rsp_valid", 32'(rsp_valid), 32'd0);
      last    = (i == waits);
      pready  = last;
      pslverr = last ? err : 1'b1;
      prdata  = last ? rd : 16'($urandom);
    end

    @(negedge clk);
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = 16'($urandom);
    check("resp_psel", 32'(psel), 32'd0);
    check("resp_penable", 32'(penable), 32'd0);
    check("resp_valid", 32'(rsp_valid), 32'd1);
    check("resp_rdata", 32'(rsp_rdata), 32'(e_rd));
    check("resp_err", 32'(rsp_err), 32'(e_err));
    check("resp_timeout", 32'(rsp_timeout), 32'(e_to));

    for (int i = 0; i < rdly; i++) begin
      @(negedge clk);
      check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      check("hold_rsp_rdata", 32'(rsp_rdata), 32'(e_rd));
      check("hold_rsp_err", 32'(rsp_err), 32'(e_err));
      check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      check("hold_psel", 32'(psel), 32'd0);
    end

    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    check("post_rsp_valid", 32'(rsp_valid), 32'd0);
    check("post_cmd_ready", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_psel", 32'(psel), 32'd0);
    check("rst_penable", 32'(penable), 32'd0);
    check("rst_paddr", 32'(paddr), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    // directed scenarios
    xfer(1'b1, 20'h00010, 16'hBEEF, 2'b11, 0, 16'h0000, 1'b0, 0, 1'b0);
    xfer(1'b0, 20'h80004, 16'h1234, 2'b11, 3, 16'hABCD, 1'b0, 0, 1'b0);
    xfer(1'b0, 20'h00008, 16'h0000, 2'b00, 2, 16'h5A5A, 1'b1, 1, 1'b0);
    xfer(1'b0, 20'h00008, 16'h0000, 2'b00, 4, 16'h1111, 1'b0, 0, 1'b0);
    xfer(1'b0, 20'h80100, 16'h0000, 2'b00, 1000, 16'h7777, 1'b0, 0, 1'b0);
    xfer(1'b1, 20'h00200, 16'hC0DE, 2'b01, TO - 1, 16'h0000, 1'b0, 0, 1'b0);
    xfer(1'b1, 20'h80200, 16'hC0DE, 2'b10, TO, 16'h0000, 1'b0, 0, 1'b0);
    xfer(1'b0, 20'h00044, 16'h0000, 2'b11, 1, 16'h4242, 1'b0, 5, 1'b1);

    // reset in the middle of an ACCESS phase
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 20'h80020;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("pre_reset_penable", 32'(penable), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_reset_psel", 32'(psel), 32'd0);
    check("mid_reset_penable", 32'(penable), 32'd0);
    check("mid_reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_reset_cmd_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    xfer(1'b0, 20'h80020, 16'h0000, 2'b00, 1, 16'h9999, 1'b0, 0, 1'b0);

    // randomized transfers
    for (int k = 0; k < 30; k++) begin
      int w;
      case ($urandom_range(0, 5))
        0:       w = TO - 1;
        1:       w = TO + $urandom_range(0, 4);
        default: w = $urandom_range(0, 3);
      endcase
      xfer(1'($urandom), 20'($urandom), 16'($urandom), 2'($urandom), w,
           16'($urandom), 1'($urandom), $urandom_range(0, 3), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
